// File: rtl/uart_tx_fifo_if.sv
// Bus-side and transmitter-side signals of the UART transmit FIFO, bundled with
// master (bus + transmitter) and slave (the FIFO) views.
interface uart_tx_fifo_if #(
  parameter int DEPTH_LOG2 = 4
);
  // Write side: a byte is taken on any rising edge with wr_en high while the
  //   registered full is low; with full high it is dropped and overflow sets.
  // Transmit side: tx_start pulses one cycle while tx_ready is high; the
  //   transmitter latches tx_data on the next edge and then drops tx_ready
  //   until its frame is done. tx_data is stable from one pop to the next.
  logic [7:0]          wr_data;
  logic                wr_en;
  logic                full;
  logic                empty;
  logic [DEPTH_LOG2:0] level;
  logic                overflow;
  logic                clr_overflow;
  logic [7:0]          tx_data;
  logic                tx_start;
  logic                tx_ready;
  logic [1:0]          fsm_state;

  modport master (
    output wr_data, wr_en, clr_overflow, tx_ready,
    input  full, empty, level, overflow, tx_data, tx_start, fsm_state
  );

  modport slave (
    input  wr_data, wr_en, clr_overflow, tx_ready,
    output full, empty, level, overflow, tx_data, tx_start, fsm_state
  );
endinterface

// File: rtl/uart_tx_fifo.sv
// Circular byte FIFO feeding a UART transmitter through a one-pulse start
// handshake, with registered occupancy flags and a sticky overflow bit.
module uart_tx_fifo #(
  parameter int DEPTH_LOG2 = 4
) (
  input logic          clk,
  input logic          rst,
  uart_tx_fifo_if.slave bus
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_LVL = (DEPTH_LOG2 + 1)'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_WAIT  = 2'd2,
    S_BUSY  = 2'd3
  } state_t;

  state_t                state;
  logic [7:0]            mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic [DEPTH_LOG2:0]   level;
  logic [DEPTH_LOG2:0]   level_nxt;
  logic                  full_q;
  logic                  empty_q;
  logic                  ovf_q;
  logic [7:0]            tx_data_q;
  logic                  tx_start_q;
  logic                  wr_acc;
  logic                  pop;

  // Both decisions use the registered flags, so a write while full is dropped
  // even if a pop frees a slot on the same edge.
  assign wr_acc = bus.wr_en && !full_q;
  assign pop    = (state == S_IDLE) && !empty_q && bus.tx_ready;

  always_comb begin
    level_nxt = level;
    case ({wr_acc, pop})
      2'b10:   level_nxt = level + 1'b1;
      2'b01:   level_nxt = level - 1'b1;
      default: level_nxt = level;
    endcase
  end

  always_ff @(posedge clk) begin
    if (wr_acc) mem[wr_ptr] <= bus.wr_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level   <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
      ovf_q   <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
      if (pop)    rd_ptr <= rd_ptr + 1'b1;
      level   <= level_nxt;
      full_q  <= (level_nxt == FULL_LVL);
      empty_q <= (level_nxt == '0);
      if (bus.wr_en && full_q) ovf_q <= 1'b1;
      else if (bus.clr_overflow) ovf_q <= 1'b0;
    end
  end

  // Drain FSM: WAIT absorbs the transmitter's one-cycle-late tx_ready drop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      tx_data_q  <= 8'h00;
      tx_start_q <= 1'b0;
    end else begin
      tx_start_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (pop) begin
            tx_data_q  <= mem[rd_ptr];
            tx_start_q <= 1'b1;
            state      <= S_START;
          end
        end
        S_START: state <= S_WAIT;
        S_WAIT:  if (!bus.tx_ready) state <= S_BUSY;
        S_BUSY:  if (bus.tx_ready) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.full      = full_q;
  assign bus.empty     = empty_q;
  assign bus.level     = level;
  assign bus.overflow  = ovf_q;
  assign bus.tx_data   = tx_data_q;
  assign bus.tx_start  = tx_start_q;
  assign bus.fsm_state = state;
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: directed table, hand sequences and random traffic
// against a queue model of the FIFO contents and a simple transmitter model.
module tb_uart_tx_fifo;
  localparam int DL    = 4;
  localparam int DEPTH = 16;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  uart_tx_fifo_if #(.DEPTH_LOG2(DL)) bus ();
  uart_tx_fifo #(.DEPTH_LOG2(DL)) dut (.clk(clk), .rst(rst), .bus(bus));

  int total = 0;
  int bad   = 0;

  // scoreboard: bytes held in the FIFO in transmit order
  logic [7:0] exp_q[$];
  logic       ovf_exp = 1'b0;

  // transmitter model or manually forced tx_ready
  logic xmtr_en     = 1'b0;
  logic ready_force = 1'b0;
  logic xm_ready;
  int   xm_cnt;
  int   frame_len   = 2;
  assign bus.tx_ready = xmtr_en ? xm_ready : ready_force;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      xm_ready <= 1'b1;
      xm_cnt   <= 0;
    end else if (xmtr_en && xm_ready && bus.tx_start) begin
      xm_ready <= 1'b0;
      xm_cnt   <= frame_len;
    end else if (!xm_ready) begin
      if (xm_cnt == 0) xm_ready <= 1'b1;
      else xm_cnt <= xm_cnt - 1;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  // One clock: drive at negedge, sample at the following negedge, update model.
  task automatic step(input logic we, input logic [7:0] d, input logic clr, input logic rdy);
    logic       full_pre;
    logic [7:0] e;
    full_pre = (exp_q.size() == DEPTH);
    bus.wr_en        = we;
    bus.wr_data      = d;
    bus.clr_overflow = clr;
    ready_force      = rdy;
    @(posedge clk);
    @(negedge clk);
    bus.wr_en        = 1'b0;
    bus.clr_overflow = 1'b0;
    if (bus.tx_start) begin
      if (xmtr_en) chk("start_while_busy", int'(bus.tx_ready), 1);
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL spurious_start: got start with data %0h, want no start", bus.tx_data);
      end else begin
        e = exp_q.pop_front();
        chk("tx_data", int'(bus.tx_data), int'(e));
      end
    end
    if (we && !full_pre) exp_q.push_back(d);
    if (we && full_pre) ovf_exp = 1'b1;
    else if (clr) ovf_exp = 1'b0;
    chk("level", int'(bus.level), exp_q.size());
    chk("full", int'(bus.full), int'(exp_q.size() == DEPTH));
    chk("empty", int'(bus.empty), int'(exp_q.size() == 0));
    chk("overflow", int'(bus.overflow), int'(ovf_exp));
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < budget) begin
      step(1'b0, 8'h00, 1'b0, 1'b0);
      n++;
    end
    chk("drain_timeout", exp_q.size(), 0);
    for (int i = 0; i < 12; i++) step(1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  typedef struct {
    logic       we;
    logic [7:0] d;
    logic       rdy;
    int         lvl;
    logic       st;
    logic [7:0] data;
  } vec_t;
  vec_t tbl[13];

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish, want finish");
    $fatal(1);
  end

  initial begin
    bus.wr_en = 1'b0;
    bus.wr_data = 8'h00;
    bus.clr_overflow = 1'b0;
    // single byte, slow handshake, wait-state queueing
    tbl[0]  = '{1'b1, 8'hA5, 1'b1, 1, 1'b0, 8'h00};
    tbl[1]  = '{1'b0, 8'h00, 1'b1, 0, 1'b1, 8'hA5};
    tbl[2]  = '{1'b0, 8'h00, 1'b1, 0, 1'b0, 8'h00};
    tbl[3]  = '{1'b0, 8'h00, 1'b1, 0, 1'b0, 8'h00};
    tbl[4]  = '{1'b1, 8'h3C, 1'b1, 1, 1'b0, 8'h00};
    tbl[5]  = '{1'b0, 8'h00, 1'b0, 1, 1'b0, 8'h00};
    tbl[6]  = '{1'b0, 8'h00, 1'b0, 1, 1'b0, 8'h00};
    tbl[7]  = '{1'b0, 8'h00, 1'b1, 1, 1'b0, 8'h00};
    tbl[8]  = '{1'b0, 8'h00, 1'b1, 0, 1'b1, 8'h3C};
    tbl[9]  = '{1'b0, 8'h00, 1'b1, 0, 1'b0, 8'h00};
    tbl[10] = '{1'b0, 8'h00, 1'b0, 0, 1'b0, 8'h00};
    tbl[11] = '{1'b0, 8'h00, 1'b1, 0, 1'b0, 8'h00};
    tbl[12] = '{1'b0, 8'h00, 1'b1, 0, 1'b0, 8'h00};

    #2 rst = 1'b1;
    #1;
    chk("rst_tx_start", int'(bus.tx_start), 0);
    chk("rst_tx_data", int'(bus.tx_data), 0);
    chk("rst_full", int'(bus.full), 0);
    chk("rst_empty", int'(bus.empty), 1);
    chk("rst_level", int'(bus.level), 0);
    chk("rst_overflow", int'(bus.overflow), 0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 13; i++) begin
      step(tbl[i].we, tbl[i].d, 1'b0, tbl[i].rdy);
      chk("tbl_level", int'(bus.level), tbl[i].lvl);
      chk("tbl_start", int'(bus.tx_start), int'(tbl[i].st));
      if (tbl[i].st) chk("tbl_data", int'(bus.tx_data), int'(tbl[i].data));
    end

    // burst fill with transmitter stalled, then overflow handling
    for (int i = 1; i <= 16; i++) step(1'b1, 8'(i), 1'b0, 1'b0);
    chk("burst_full", int'(bus.full), 1);
    chk("burst_level", int'(bus.level), 16);
    step(1'b1, 8'hFF, 1'b0, 1'b0);
    chk("ovf_set", int'(bus.overflow), 1);
    chk("ovf_level", int'(bus.level), 16);
    step(1'b1, 8'hFF, 1'b1, 1'b0);
    chk("ovf_set_beats_clr", int'(bus.overflow), 1);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    chk("ovf_clr", int'(bus.overflow), 0);
    frame_len = 3;
    xmtr_en = 1'b1;
    drain(400);

    // simultaneous write and pop at level 3
    xmtr_en = 1'b0;
    step(1'b1, 8'h11, 1'b0, 1'b0);
    step(1'b1, 8'h22, 1'b0, 1'b0);
    step(1'b1, 8'h33, 1'b0, 1'b0);
    chk("sim_level_pre", int'(bus.level), 3);
    xmtr_en = 1'b1;
    step(1'b1, 8'h5A, 1'b0, 1'b0);
    chk("sim_level", int'(bus.level), 3);
    chk("sim_start", int'(bus.tx_start), 1);
    drain(200);

    // random traffic, wraps the pointers many times
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 15) == 0) frame_len = $urandom_range(0, 6);
      step(($urandom_range(0, 99) < 40), 8'($urandom), ($urandom_range(0, 19) == 0), 1'b0);
    end
    drain(600);

    // reset while 5 bytes are queued and the FSM waits on a long frame
    frame_len = 30;
    for (int i = 0; i < 6; i++) step(1'b1, 8'(8'hB0 + i), 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    chk("pre_rst_level", int'(bus.level), 5);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_tx_start", int'(bus.tx_start), 0);
    chk("mid_rst_level", int'(bus.level), 0);
    chk("mid_rst_empty", int'(bus.empty), 1);
    exp_q.delete();
    ovf_exp = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    frame_len = 2;
    for (int i = 0; i < 10; i++) step(1'b0, 8'h00, 1'b0, 1'b0);
    step(1'b1, 8'hC3, 1'b0, 1'b0);
    drain(50);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
